// File: rtl/regfile_pkg.sv
// Shared constants and FSM encoding for the 2R1W register file.
// Imported by reg_cell32 and regfile_2r1w.
package regfile_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/reg_cell32.sv
// One DATA_W-bit storage word: async active-low clear, sync load, sync clear.
// Ports: clock, rst_n, load, clear, d -> q. Sync clear has priority.
module reg_cell32
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  logic [DATA_W-1:0] val_q;
  logic [DATA_W-1:0] val_d;

  always_comb begin
    val_d = val_q;
    if (clear) begin
      val_d = '0;
    end else if (load) begin
      val_d = d;
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign q = val_q;

endmodule

// File: rtl/regfile_2r1w.sv
// 32x32 register file: one write port, two registered read ports with
// write bypass, clear sweep FSM. r0 reads 0. busy/write_ack registered.
module regfile_2r1w
  import regfile_pkg::*;
(
  input  logic              clock,
  input  logic              ctrl_reset_n,
  input  logic              ctrl_writeEnable,
  input  logic [ADDR_W-1:0] ctrl_writeReg,
  input  logic [DATA_W-1:0] data_writeReg,
  input  logic [ADDR_W-1:0] ctrl_readRegA,
  input  logic [ADDR_W-1:0] ctrl_readRegB,
  input  logic              ctrl_clear,
  output logic [DATA_W-1:0] data_readRegA,
  output logic [DATA_W-1:0] data_readRegB,
  output logic              write_ack,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              ack_q, ack_d;
  logic [DATA_W-1:0] rd_a_q, rd_a_d;
  logic [DATA_W-1:0] rd_b_q, rd_b_d;

  logic                wr_acc;
  logic [NUM_REGS-1:1] wr_en;
  logic [NUM_REGS-1:1] clr_en;
  logic [DATA_W-1:0]   regs [NUM_REGS];

  // A clear request in the same cycle wins over the write.
  assign wr_acc = (state_q == IDLE)
                & ctrl_writeEnable
                & ~ctrl_clear;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (ctrl_clear) begin
          state_d = CLEAR;
          cnt_d   = ADDR_W'(1);
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + ADDR_W'(1);
        // Wrap 31->0 marks the last swept word.
        if (cnt_d == '0) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_en  = '0;
    clr_en = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      wr_en[i]  = wr_acc
                & (ctrl_writeReg == ADDR_W'(i));
      clr_en[i] = (state_q == CLEAR)
                & (cnt_q == ADDR_W'(i));
    end
  end

  assign regs[0] = '0;

  for (genvar g = 1; g < NUM_REGS; g++) begin : g_reg
    reg_cell32 u_cell (
      .clock (clock),
      .rst_n (ctrl_reset_n),
      .load  (wr_en[g]),
      .clear (clr_en[g]),
      .d     (data_writeReg),
      .q     (regs[g])
    );
  end

  always_comb begin
    ack_d  = wr_acc;
    rd_a_d = regs[ctrl_readRegA];
    rd_b_d = regs[ctrl_readRegB];
    if (wr_acc && ctrl_readRegA != '0
        && ctrl_writeReg == ctrl_readRegA) begin
      rd_a_d = data_writeReg;
    end
    if (wr_acc && ctrl_readRegB != '0
        && ctrl_writeReg == ctrl_readRegB) begin
      rd_b_d = data_writeReg;
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      rd_a_q  <= '0;
      rd_b_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      rd_a_q  <= rd_a_d;
      rd_b_q  <= rd_b_d;
    end
  end

  assign data_readRegA = rd_a_q;
  assign data_readRegB = rd_b_q;
  assign write_ack     = ack_q;
  assign busy          = (state_q == CLEAR);

endmodule

// File: tb/tb_regfile_2r1w.sv
// Bench for regfile_2r1w: directed table, hand sequences, random vs model.
// Model holds a plain memory array plus a sweep index.
module tb_regfile_2r1w;

  logic        clock = 1'b0;
  logic        ctrl_reset_n;
  logic        ctrl_writeEnable;
  logic [4:0]  ctrl_writeReg;
  logic [31:0] data_writeReg;
  logic [4:0]  ctrl_readRegA;
  logic [4:0]  ctrl_readRegB;
  logic        ctrl_clear;
  logic [31:0] data_readRegA;
  logic [31:0] data_readRegB;
  logic        write_ack;
  logic        busy;

  always #5 clock = ~clock;

  regfile_2r1w dut (
    .clock            (clock),
    .ctrl_reset_n     (ctrl_reset_n),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .ctrl_readRegA    (ctrl_readRegA),
    .ctrl_readRegB    (ctrl_readRegB),
    .ctrl_clear       (ctrl_clear),
    .data_readRegA    (data_readRegA),
    .data_readRegB    (data_readRegB),
    .write_ack        (write_ack),
    .busy             (busy)
  );

  int nvec = 0;
  int nbad = 0;

  logic [31:0] mem [32];
  logic        m_busy;
  int          m_idx;
  logic [31:0] e_a, e_b;
  logic        e_ack;

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] xa;
    logic [31:0] xb;
    logic        xack;
  } vec_t;

  vec_t tbl [7];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h want %h @%0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) mem[i] = '0;
    m_busy = 1'b0;
    m_idx  = 0;
  endfunction

  // Evaluate one rising edge from the inputs held across it.
  function automatic void model_edge();
    logic acc;
    acc   = !m_busy && ctrl_writeEnable && !ctrl_clear;
    e_ack = acc;
    e_a   = mem[ctrl_readRegA];
    e_b   = mem[ctrl_readRegB];
    if (acc && ctrl_readRegA != 0 && ctrl_writeReg == ctrl_readRegA)
      e_a = data_writeReg;
    if (acc && ctrl_readRegB != 0 && ctrl_writeReg == ctrl_readRegB)
      e_b = data_writeReg;
    if (m_busy) begin
      mem[m_idx] = '0;
      m_idx++;
      if (m_idx == 32) m_busy = 1'b0;
    end else if (ctrl_clear) begin
      m_busy = 1'b1;
      m_idx  = 1;
    end else if (acc && ctrl_writeReg != 0) begin
      mem[ctrl_writeReg] = data_writeReg;
    end
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    model_edge();
    chk("rd_a", data_readRegA, e_a);
    chk("rd_b", data_readRegB, e_b);
    chk("ack", {31'b0, write_ack}, {31'b0, e_ack});
    chk("busy", {31'b0, busy}, {31'b0, m_busy});
  endtask

  task automatic idle_in();
    ctrl_writeEnable = 1'b0;
    ctrl_clear       = 1'b0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    ctrl_writeEnable = 1'b1;
    ctrl_writeReg    = a;
    data_writeReg    = d;
  endtask

  int cnt;

  initial begin
    tbl[0] = '{1'b0, 5'd0,  32'h0,        5'd5,  5'd31,
               32'h0,        32'h0,        1'b0};
    tbl[1] = '{1'b1, 5'd7,  32'hDEADBEEF, 5'd1,  5'd0,
               32'h0,        32'h0,        1'b1};
    tbl[2] = '{1'b0, 5'd0,  32'h0,        5'd7,  5'd7,
               32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
    tbl[3] = '{1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd7,
               32'h0,        32'hDEADBEEF, 1'b1};
    tbl[4] = '{1'b0, 5'd0,  32'h0,        5'd0,  5'd0,
               32'h0,        32'h0,        1'b0};
    tbl[5] = '{1'b1, 5'd12, 32'h12345678, 5'd12, 5'd12,
               32'h12345678, 32'h12345678, 1'b1};
    tbl[6] = '{1'b0, 5'd0,  32'h0,        5'd13, 5'd12,
               32'h0,        32'h12345678, 1'b0};

    ctrl_reset_n  = 1'b0;
    idle_in();
    ctrl_writeReg = '0;
    data_writeReg = '0;
    ctrl_readRegA = 5'd5;
    ctrl_readRegB = 5'd31;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    chk("rst_a", data_readRegA, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    ctrl_reset_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      ctrl_writeEnable = tbl[i].we;
      ctrl_writeReg    = tbl[i].wa;
      data_writeReg    = tbl[i].wd;
      ctrl_readRegA    = tbl[i].ra;
      ctrl_readRegB    = tbl[i].rb;
      step();
      chk("tbl_a", data_readRegA, tbl[i].xa);
      chk("tbl_b", data_readRegB, tbl[i].xb);
      chk("tbl_ack", {31'b0, write_ack}, {31'b0, tbl[i].xack});
    end

    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i));
      step();
    end
    idle_in();

    wr(5'd3, 32'hAA);
    ctrl_clear = 1'b1;
    step();
    chk("clr_wr_ack", {31'b0, write_ack}, 32'h0);
    idle_in();
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      ctrl_readRegA = 5'd2;
      ctrl_readRegB = 5'd3;
      if (cnt == 5) wr(5'd31, 32'h55);
      if (cnt == 10) begin
        ctrl_readRegA = 5'd31;
        ctrl_readRegB = 5'd1;
      end
      if (cnt == 15) ctrl_clear = 1'b1;
      step();
      if (cnt == 5) chk("busy_wr_ack", {31'b0, write_ack}, 32'h0);
      if (cnt == 10) begin
        chk("mid_r31", data_readRegA, 32'd31);
        chk("mid_r1", data_readRegB, 32'd0);
      end
      idle_in();
    end
    chk("busy_cycles", 32'(cnt), 32'd31);

    for (int i = 0; i < 16; i++) begin
      ctrl_readRegA = 5'(i);
      ctrl_readRegB = 5'(i + 16);
      step();
    end
    ctrl_readRegA = 5'd3;
    step();
    chk("r3_after", data_readRegA, 32'h0);

    wr(5'd5, 32'h5555);
    step();
    idle_in();
    ctrl_clear = 1'b1;
    step();
    ctrl_clear = 1'b0;
    repeat (9) step();
    #2;
    ctrl_reset_n = 1'b0;
    model_reset();
    #1;
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_a", data_readRegA, 32'h0);
    chk("mrst_b", data_readRegB, 32'h0);
    @(posedge clock);
    #1;
    ctrl_reset_n = 1'b1;
    wr(5'd9, 32'h77);
    ctrl_readRegA = 5'd5;
    step();
    chk("post_rst_ack", {31'b0, write_ack}, 32'h1);
    chk("post_rst_r5", data_readRegA, 32'h0);
    idle_in();
    ctrl_readRegA = 5'd9;
    step();
    chk("post_rst_r9", data_readRegA, 32'h77);

    for (int i = 0; i < 400; i++) begin
      ctrl_writeEnable = 1'($urandom_range(0, 1));
      ctrl_writeReg    = 5'($urandom);
      data_writeReg    = $urandom;
      ctrl_readRegA    = 5'($urandom);
      ctrl_readRegB    = ($urandom_range(0, 3) == 0)
                       ? ctrl_writeReg : 5'($urandom);
      ctrl_clear       = ($urandom_range(0, 59) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nbad);
    $finish;
  end

endmodule
